regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU, single-cycle results) and B (load/multiply, multi-cycle results).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers onto registered RegWrite/WriteRegister/WriteData outputs that drive the register file directly.
- Writes to register 0 are consumed but never issued to the port, and same-destination writes retire in age order.

Parameters:
RR_ENABLE, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins when both buffers are full (subject to the same-register age rule).
ZERO_REG_PROTECT, 1, 1 = a granted entry targeting register 0 drives RegWrite_40 = 0; 0 = issue it like any other register.

Ports:
Clk_40  in  1  clock; all state updates on posedge
Reset_n_40  in  1  asynchronous active-low reset
ValidA_40  in  1  requester A has a writeback
RegA_40  in  5  destination register, A
DataA_40  in  32  write data, A
ReadyA_40  out  1  A buffer can accept this cycle
ValidB_40  in  1  requester B has a writeback
RegB_40  in  5  destination register, B
DataB_40  in  32  write data, B
ReadyB_40  out  1  B buffer can accept this cycle
RegWrite_40  out  1  register-file write enable (registered)
WriteRegister_40  out  5  register-file write address (registered)
WriteData_40  out  32  register-file write data (registered)
Pending_40  out  2  number of full holding buffers (0..2)

Behaviour:
Reset:
- Reset_n_40 low clears immediately, regardless of clock: both buffers EMPTY, RegWrite_40 = 0, WriteRegister_40 = 0, WriteData_40 = 0, Pending_40 = 0, RR pointer = A-next, age bit cleared.
- Reset mid-operation discards any buffered entries; no partial write is issued.

Acceptance:
- Each buffer is EMPTY or FULL. ReadyX_40 = (bufX EMPTY) or (bufX FULL and granted this cycle).
- Ready is therefore combinational from buffer state and grant only; it never depends on ValidX_40.
- A transfer occurs at posedge when ValidX_40 and ReadyX_40 are both high. RegX/DataX are captured into bufX.
- A requester's Valid/Reg/Data must stay stable while Ready is low. The block does not check this.

Arbitration (combinational from buffer state, acted on at posedge):
- Only full buffers compete; input ports never bypass the buffers.
- Exactly one full buffer: it is granted.
- Both full, different registers:
  - RR_ENABLE = 1: grant the side not granted most recently (RR pointer).
  - RR_ENABLE = 0: grant A.
- Both full, same register: grant the older entry (age bit).
  - Age bit = the side accepted first.
  - If both sides were accepted in the same cycle, B is older.
- The RR pointer updates only when both buffers were full at grant time.

Write issue:
- The granted entry empties at posedge. In the same posedge the outputs load as follows:
  - WriteRegister_40 = buf.reg and WriteData_40 = buf.data.
  - RegWrite_40 = 1, except RegWrite_40 = 0 when buf.reg == 0 and ZERO_REG_PROTECT = 1.
- No grant in a cycle: RegWrite_40 = 0 next cycle; address and data hold their previous values.
- Latency: accepted at posedge N, earliest write issue visible after posedge N+1. The register file commits it at posedge N+2.
- Throughput: one write per cycle. A side's buffer refills in the same cycle it is granted.
- Worst-case wait for a full buffer under contention: 1 grant.

Pending_40:
- Registered count of full buffers; updated every posedge.

Test Plan:
- Reset hold: assert Reset_n_40 = 0 with ValidA_40 = 1 -> RegWrite_40 = 0, ReadyA_40 = 1, Pending_40 = 0. After release, A(reg 5, 0x1234) accepted at edge N -> RegWrite_40 = 1, WriteRegister_40 = 5, WriteData_40 = 0x1234 after edge N+1, RegWrite_40 = 0 after edge N+2.
- Contention round-robin: A and B valid continuously with distinct registers (A: 3, 0xAAAA0000+i; B: 4, 0xBBBB0000+i) -> writes alternate A, B, A, B. No side waits more than 1 grant. Pending_40 = 2 in steady state.
- Same-register ordering: B(reg 7, 0x0B) accepted at edge N, A(reg 7, 0x0A) at edge N+1 -> 0x0B issued before 0x0A; register 7 finally holds 0x0A. Same-cycle acceptance of A(reg 7, 0x0A) and B(reg 7, 0x0B) -> B issued first, final value 0x0A.
- Zero register: A(reg 0, 0xDEAD) with ZERO_REG_PROTECT = 1 -> entry consumed, ReadyA_40 returns to 1, RegWrite_40 stays 0 for the whole test. With ZERO_REG_PROTECT = 0 -> RegWrite_40 = 1, WriteRegister_40 = 0.
- Fixed priority: RR_ENABLE = 0, both valid continuously with distinct registers -> A granted every cycle, ReadyB_40 stays 0, Pending_40 = 2. Drop ValidA_40 -> B granted the next cycle.
- Reset mid-operation: both buffers full, pull Reset_n_40 low between edges -> outputs and Pending_40 clear immediately, no RegWrite_40 pulse for the discarded entries after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two one-entry holding buffers (A = ALU,
// B = load/multiply) drained one per cycle onto registered write outputs.
// Same-destination entries retire oldest first; register 0 can be suppressed.
//
// Handshake: a side transfers at posedge when its Valid and Ready are both
// high. Ready depends only on buffer state and the current grant, never on
// Valid, so a requester may hold Valid/Reg/Data stable until it sees Ready.
module regfile_write_arbiter #(
   parameter bit RR_ENABLE        = 1'b1,
   parameter bit ZERO_REG_PROTECT = 1'b1
) (
   input  logic        Clk_40,
   input  logic        Reset_n_40,
   input  logic        ValidA_40,
   input  logic [4:0]  RegA_40,
   input  logic [31:0] DataA_40,
   output logic        ReadyA_40,
   input  logic        ValidB_40,
   input  logic [4:0]  RegB_40,
   input  logic [31:0] DataB_40,
   output logic        ReadyB_40,
   output logic        RegWrite_40,
   output logic [4:0]  WriteRegister_40,
   output logic [31:0] WriteData_40,
   output logic [1:0]  Pending_40
);

   // holding buffers
   logic        a_full_q, b_full_q;
   logic [4:0]  a_reg_q, b_reg_q;
   logic [31:0] a_data_q, b_data_q;

   // arbitration state: rr_q = 1 means B is next; age_q = 1 means B is older
   logic rr_q, rr_d;
   logic age_q, age_d;

   // registered write port
   logic        we_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   logic [1:0]  pending_q, pending_d;

   logic        both_full, pick_b;
   logic        grant_a, grant_b, grant_any;
   logic        acc_a, acc_b;
   logic        a_full_d, b_full_d;
   logic [4:0]  issue_reg;
   logic [31:0] issue_data;
   logic        issue_we;

   assign both_full = a_full_q & b_full_q;

   // Choose B only when both compete: age wins on a shared destination,
   // otherwise the round-robin pointer (or fixed A priority) decides.
   always_comb begin
      pick_b = 1'b0;
      if (both_full) begin
         if (a_reg_q == b_reg_q) begin
            pick_b = age_q;
         end else if (RR_ENABLE) begin
            pick_b = rr_q;
         end else begin
            pick_b = 1'b0;
         end
      end
   end

   assign grant_a   = a_full_q & ~(both_full & pick_b);
   assign grant_b   = b_full_q & ~grant_a;
   assign grant_any = grant_a | grant_b;

   assign ReadyA_40 = ~a_full_q | grant_a;
   assign ReadyB_40 = ~b_full_q | grant_b;

   assign acc_a = ValidA_40 & ReadyA_40;
   assign acc_b = ValidB_40 & ReadyB_40;

   assign a_full_d = acc_a | (a_full_q & ~grant_a);
   assign b_full_d = acc_b | (b_full_q & ~grant_b);

   assign pending_d = 2'(a_full_d) + 2'(b_full_d);

   // Pointer moves to the side that lost, only when both were competing.
   assign rr_d = both_full ? grant_a : rr_q;

   // Age tracks which side was accepted first; a same-cycle pair makes B older.
   // It only matters while both are full, and any new acceptance rewrites it.
   always_comb begin
      age_d = age_q;
      if (acc_a) begin
         age_d = 1'b1;
      end else if (acc_b) begin
         age_d = 1'b0;
      end
   end

   assign issue_reg  = grant_a ? a_reg_q : b_reg_q;
   assign issue_data = grant_a ? a_data_q : b_data_q;
   assign issue_we   = grant_any & ~(ZERO_REG_PROTECT && (issue_reg == 5'd0));

   // Buffer fill/drain; a granted buffer may be refilled in the same edge.
   always_ff @(posedge Clk_40 or negedge Reset_n_40) begin
      if (!Reset_n_40) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_reg_q  <= 5'd0;
         b_reg_q  <= 5'd0;
         a_data_q <= 32'd0;
         b_data_q <= 32'd0;
      end else begin
         a_full_q <= a_full_d;
         b_full_q <= b_full_d;
         if (acc_a) begin
            a_reg_q  <= RegA_40;
            a_data_q <= DataA_40;
         end
         if (acc_b) begin
            b_reg_q  <= RegB_40;
            b_data_q <= DataB_40;
         end
      end
   end

   // Round-robin pointer and age bit.
   always_ff @(posedge Clk_40 or negedge Reset_n_40) begin
      if (!Reset_n_40) begin
         rr_q  <= 1'b0;
         age_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         age_q <= age_d;
      end
   end

   // Registered write port: address/data load on any grant, hold otherwise.
   always_ff @(posedge Clk_40 or negedge Reset_n_40) begin
      if (!Reset_n_40) begin
         we_q      <= 1'b0;
         waddr_q   <= 5'd0;
         wdata_q   <= 32'd0;
         pending_q <= 2'd0;
      end else begin
         we_q      <= issue_we;
         pending_q <= pending_d;
         if (grant_any) begin
            waddr_q <= issue_reg;
            wdata_q <= issue_data;
         end
      end
   end

   assign RegWrite_40      = we_q;
   assign WriteRegister_40 = waddr_q;
   assign WriteData_40     = wdata_q;
   assign Pending_40       = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Three instances share inputs:
// index 0 = defaults, 1 = fixed priority, 2 = register 0 not protected.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_a, valid_b;
   logic [4:0]  reg_a, reg_b;
   logic [31:0] data_a, data_b;

   logic [2:0]        rdy_a, rdy_b, rw;
   logic [2:0][4:0]   wr;
   logic [2:0][31:0]  wd;
   logic [2:0][1:0]   pend;

   logic [36:0] a_src[$];
   logic [36:0] b_src[$];
   logic [36:0] exp_q[$];
   logic [31:0] rf [32];
   int          n_vec = 0;
   int          n_miss = 0;

   // clock / reset
   always #5 clk = ~clk;

   regfile_write_arbiter u_dut (
      .Clk_40(clk), .Reset_n_40(rst_n),
      .ValidA_40(valid_a), .RegA_40(reg_a), .DataA_40(data_a), .ReadyA_40(rdy_a[0]),
      .ValidB_40(valid_b), .RegB_40(reg_b), .DataB_40(data_b), .ReadyB_40(rdy_b[0]),
      .RegWrite_40(rw[0]), .WriteRegister_40(wr[0]), .WriteData_40(wd[0]),
      .Pending_40(pend[0]));

   regfile_write_arbiter #(.RR_ENABLE(1'b0)) u_dut_fp (
      .Clk_40(clk), .Reset_n_40(rst_n),
      .ValidA_40(valid_a), .RegA_40(reg_a), .DataA_40(data_a), .ReadyA_40(rdy_a[1]),
      .ValidB_40(valid_b), .RegB_40(reg_b), .DataB_40(data_b), .ReadyB_40(rdy_b[1]),
      .RegWrite_40(rw[1]), .WriteRegister_40(wr[1]), .WriteData_40(wd[1]),
      .Pending_40(pend[1]));

   regfile_write_arbiter #(.ZERO_REG_PROTECT(1'b0)) u_dut_nz (
      .Clk_40(clk), .Reset_n_40(rst_n),
      .ValidA_40(valid_a), .RegA_40(reg_a), .DataA_40(data_a), .ReadyA_40(rdy_a[2]),
      .ValidB_40(valid_b), .RegB_40(reg_b), .DataB_40(data_b), .ReadyB_40(rdy_b[2]),
      .RegWrite_40(rw[2]), .WriteRegister_40(wr[2]), .WriteData_40(wd[2]),
      .Pending_40(pend[2]));

   // driver: reset all instances and clear the stimulus/expected state
   task automatic do_reset();
      a_src.delete();
      b_src.delete();
      exp_q.delete();
      valid_a = 1'b0;
      valid_b = 1'b0;
      rst_n   = 1'b0;
      foreach (rf[i]) rf[i] = 32'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // driver: offer the head of each source queue for one clock, handshaking
   // against instance s; outputs are then observed 1 time unit after the edge
   task automatic step(input int s);
      logic ha, hb;
      valid_a = (a_src.size() > 0);
      valid_b = (b_src.size() > 0);
      if (valid_a) {reg_a, data_a} = a_src[0];
      if (valid_b) {reg_b, data_b} = b_src[0];
      ha = valid_a & rdy_a[s];
      hb = valid_b & rdy_b[s];
      @(posedge clk);
      #1;
      if (ha) a_src.delete(0);
      if (hb) b_src.delete(0);
      if (rw[s]) rf[wr[s]] = wd[s];
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_a = 1'b1; reg_a = 5'd5; data_a = 32'h1234;
      valid_b = 1'b0; reg_b = 5'd0; data_b = 32'd0;
      @(posedge clk);
      #1;
      n_vec++; if (rw[0] !== 1'b0) begin n_miss++; $display("FAIL reset_we: got %b, required 0", rw[0]); end
      n_vec++; if (rdy_a[0] !== 1'b1) begin n_miss++; $display("FAIL reset_ready_a: got %b, required 1", rdy_a[0]); end
      n_vec++; if (pend[0] !== 2'd0) begin n_miss++; $display("FAIL reset_pending: got %0d, required 0", pend[0]); end
      n_vec++; if (wr[0] !== 5'd0 || wd[0] !== 32'd0) begin n_miss++; $display("FAIL reset_addr_data: got r%0d=%h, required r0=0", wr[0], wd[0]); end
      rst_n = 1'b1;
      foreach (rf[i]) rf[i] = 32'd0;
      a_src.push_back({5'd5, 32'h1234});
      step(0);
      n_vec++; if (rw[0] !== 1'b0 || pend[0] !== 2'd1) begin n_miss++; $display("FAIL first_accept: got we=%b pend=%0d, required we=0 pend=1", rw[0], pend[0]); end
      step(0);
      n_vec++; if (rw[0] !== 1'b1 || wr[0] !== 5'd5 || wd[0] !== 32'h1234) begin n_miss++; $display("FAIL first_write: got we=%b r%0d=%h, required we=1 r5=00001234", rw[0], wr[0], wd[0]); end
      step(0);
      n_vec++; if (rw[0] !== 1'b0 || wr[0] !== 5'd5 || wd[0] !== 32'h1234) begin n_miss++; $display("FAIL idle_hold: got we=%b r%0d=%h, required we=0 r5=00001234", rw[0], wr[0], wd[0]); end
   endtask

   task automatic test_round_robin();
      logic [36:0] e;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         a_src.push_back({5'd3, 32'hAAAA0000 + k});
         b_src.push_back({5'd4, 32'hBBBB0000 + k});
         exp_q.push_back({5'd3, 32'hAAAA0000 + k});
         exp_q.push_back({5'd4, 32'hBBBB0000 + k});
      end
      for (int t = 1; t <= 16; t++) begin
         step(0);
         if (t <= 11) begin
            n_vec++; if (pend[0] !== 2'd2) begin n_miss++; $display("FAIL rr_pending t%0d: got %0d, required 2", t, pend[0]); end
         end
         if (t >= 2 && t <= 13) begin
            n_vec++; if (rw[0] !== 1'b1) begin n_miss++; $display("FAIL rr_throughput t%0d: got we=%b, required 1", t, rw[0]); end
         end
         if (rw[0]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++; $display("FAIL rr_order: got extra r%0d=%h, required none", wr[0], wd[0]);
            end else begin
               e = exp_q.pop_front();
               if ({wr[0], wd[0]} !== e) begin n_miss++; $display("FAIL rr_order t%0d: got r%0d=%h, required r%0d=%h", t, wr[0], wd[0], e[36:32], e[31:0]); end
            end
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL rr_drain: got %0d writes missing, required 0", exp_q.size()); end
   endtask

   task automatic test_same_reg();
      logic [36:0] e;
      for (int v = 0; v < 2; v++) begin
         do_reset();
         if (v == 0) begin
            b_src.push_back({5'd7, 32'h0B});
            step(0);
            a_src.push_back({5'd7, 32'h0A});
         end else begin
            a_src.push_back({5'd7, 32'h0A});
            b_src.push_back({5'd7, 32'h0B});
         end
         exp_q.push_back({5'd7, 32'h0B});
         exp_q.push_back({5'd7, 32'h0A});
         for (int t = 0; t < 4; t++) begin
            step(0);
            if (rw[0]) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_miss++; $display("FAIL same_reg_order v%0d: got extra r%0d=%h, required none", v, wr[0], wd[0]);
               end else begin
                  e = exp_q.pop_front();
                  if ({wr[0], wd[0]} !== e) begin n_miss++; $display("FAIL same_reg_order v%0d: got r%0d=%h, required r%0d=%h", v, wr[0], wd[0], e[36:32], e[31:0]); end
               end
            end
         end
         n_vec++; if (rf[7] !== 32'h0A || exp_q.size() != 0) begin n_miss++; $display("FAIL same_reg_final v%0d: got r7=%h left=%0d, required r7=0000000a left=0", v, rf[7], exp_q.size()); end
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      a_src.push_back({5'd0, 32'hDEAD});
      for (int t = 1; t <= 4; t++) begin
         step(0);
         n_vec++; if (rw[0] !== 1'b0) begin n_miss++; $display("FAIL zero_protect_we t%0d: got %b, required 0", t, rw[0]); end
         if (t == 2) begin
            n_vec++; if (rdy_a[0] !== 1'b1 || pend[0] !== 2'd0) begin n_miss++; $display("FAIL zero_consumed: got ready=%b pend=%0d, required ready=1 pend=0", rdy_a[0], pend[0]); end
            n_vec++; if (wd[0] !== 32'hDEAD) begin n_miss++; $display("FAIL zero_data_load: got %h, required 0000dead", wd[0]); end
         end
      end
      do_reset();
      a_src.push_back({5'd0, 32'hDEAD});
      step(2);
      step(2);
      n_vec++; if (rw[2] !== 1'b1 || wr[2] !== 5'd0 || wd[2] !== 32'hDEAD) begin n_miss++; $display("FAIL zero_unprotected: got we=%b r%0d=%h, required we=1 r0=0000dead", rw[2], wr[2], wd[2]); end
   endtask

   task automatic test_fixed_priority();
      logic [36:0] e;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         a_src.push_back({5'd3, 32'hAAAA0000 + k});
         exp_q.push_back({5'd3, 32'hAAAA0000 + k});
      end
      for (int k = 0; k < 3; k++) begin
         b_src.push_back({5'd4, 32'hBBBB0000 + k});
         exp_q.push_back({5'd4, 32'hBBBB0000 + k});
      end
      for (int t = 1; t <= 14; t++) begin
         step(1);
         if (t <= 8) begin
            n_vec++; if (rdy_b[1] !== 1'b0 || pend[1] !== 2'd2) begin n_miss++; $display("FAIL fp_starve t%0d: got readyB=%b pend=%0d, required readyB=0 pend=2", t, rdy_b[1], pend[1]); end
         end
         if (t == 10) begin
            n_vec++; if (rw[1] !== 1'b1 || wd[1] !== 32'hBBBB0000) begin n_miss++; $display("FAIL fp_b_next: got we=%b data=%h, required we=1 data=bbbb0000", rw[1], wd[1]); end
         end
         if (rw[1]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++; $display("FAIL fp_order: got extra r%0d=%h, required none", wr[1], wd[1]);
            end else begin
               e = exp_q.pop_front();
               if ({wr[1], wd[1]} !== e) begin n_miss++; $display("FAIL fp_order t%0d: got r%0d=%h, required r%0d=%h", t, wr[1], wd[1], e[36:32], e[31:0]); end
            end
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL fp_drain: got %0d writes missing, required 0", exp_q.size()); end
      // fixed priority still yields to an older same-register entry
      do_reset();
      a_src.push_back({5'd3, 32'hA0});
      a_src.push_back({5'd7, 32'h0A});
      b_src.push_back({5'd7, 32'h0B});
      exp_q.push_back({5'd3, 32'hA0});
      exp_q.push_back({5'd7, 32'h0B});
      exp_q.push_back({5'd7, 32'h0A});
      for (int t = 1; t <= 5; t++) begin
         step(1);
         if (rw[1]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++; $display("FAIL fp_age: got extra r%0d=%h, required none", wr[1], wd[1]);
            end else begin
               e = exp_q.pop_front();
               if ({wr[1], wd[1]} !== e) begin n_miss++; $display("FAIL fp_age t%0d: got r%0d=%h, required r%0d=%h", t, wr[1], wd[1], e[36:32], e[31:0]); end
            end
         end
      end
      n_vec++; if (rf[7] !== 32'h0A || exp_q.size() != 0) begin n_miss++; $display("FAIL fp_age_final: got r7=%h left=%0d, required r7=0000000a left=0", rf[7], exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      a_src.push_back({5'd10, 32'h111});
      b_src.push_back({5'd11, 32'h222});
      step(0);
      n_vec++; if (pend[0] !== 2'd2) begin n_miss++; $display("FAIL mid_full: got pend=%0d, required 2", pend[0]); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (pend[0] !== 2'd0 || rw[0] !== 1'b0) begin n_miss++; $display("FAIL mid_async_clear: got pend=%0d we=%b, required pend=0 we=0", pend[0], rw[0]); end
      n_vec++; if (rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b1) begin n_miss++; $display("FAIL mid_ready: got readyA=%b readyB=%b, required 1 1", rdy_a[0], rdy_b[0]); end
      #1;
      rst_n = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         step(0);
         n_vec++; if (rw[0] !== 1'b0 || pend[0] !== 2'd0) begin n_miss++; $display("FAIL mid_no_write t%0d: got we=%b pend=%0d, required we=0 pend=0", t, rw[0], pend[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_same_reg();
      test_zero_reg();
      test_fixed_priority();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
